// File: rtl/jedro_1_imem_arbiter.sv
// jedro_1 instruction memory arbiter: shares the single SPROM read port between IF and LS.
// Optional IF fairness counter is compiled in with `define IMEM_ARB_FAIR_EN.
//
// owner state | meaning
// ------------+------------------------------------------------
// OWN_NONE    | no read in flight, no response this cycle
// OWN_IF      | read issued last cycle belongs to IF
// OWN_LS      | read issued last cycle belongs to LS
module jedro_1_imem_arbiter #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MAX_IF_WAIT = 4,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR   = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic [DATA_WIDTH-1:0] ls_addr_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  owner_e                owner_q, owner_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  fair_turn;
  logic                  ls_win;
  logic                  if_win;

  if (MAX_IF_WAIT < 1 || MAX_IF_WAIT > 15) begin : g_bad_max_if_wait
    $error("jedro_1_imem_arbiter: MAX_IF_WAIT must be within 1..15");
  end

`ifdef IMEM_ARB_FAIR_EN
  logic [3:0] wait_cnt_q;

  // IF takes one cycle of priority once it has waited MAX_IF_WAIT cycles.
  assign fair_turn = if_req_i && (wait_cnt_q == 4'(MAX_IF_WAIT));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wait_cnt_q <= '0;
    end else if (!if_req_i || if_win) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 4'd1;
    end
  end
`else
  assign fair_turn = 1'b0;
`endif

  // Grants are masked during reset so nothing is issued to the SPROM.
  assign ls_win   = rstn_i && ls_req_i && !fair_turn;
  assign if_win   = rstn_i && if_req_i && !ls_win;
  assign ls_gnt_o = ls_win;
  assign if_gnt_o = if_win;

  always_comb begin
    mem_addr_o = addr_q;
    if (!rstn_i) begin
      mem_addr_o = BOOT_ADDR;
    end else if (ls_win) begin
      mem_addr_o = ls_addr_i;
    end else if (if_win) begin
      mem_addr_o = if_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      addr_q <= BOOT_ADDR;
    end else if (ls_win || if_win) begin
      addr_q <= mem_addr_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A flushed IF grant still reads the SPROM but nobody owns the result.
  always_comb begin
    owner_d = OWN_NONE;
    if (ls_win) begin
      owner_d = OWN_LS;
    end else if (if_win && !flush_i) begin
      owner_d = OWN_IF;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    case (owner_q)
      OWN_IF: begin
        if (rstn_i && !flush_i) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
      end
      OWN_LS: begin
        if (rstn_i) begin
          ls_rvalid_o = 1'b1;
          ls_rdata_o  = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jedro_1_imem_arbiter.sv
// Randomized self-checking bench for jedro_1_imem_arbiter against a cycle-level reference model.
// Build with or without +define+IMEM_ARB_FAIR_EN; the model follows the same macro.
module tb_jedro_1_imem_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 4;
  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic          clk_i = 1'b0;
  logic          rstn_i, flush_i;
  logic          if_req_i, ls_req_i;
  logic [DW-1:0] if_addr_i, ls_addr_i;
  logic          if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] if_rdata_o, ls_rdata_o, mem_addr_o;
  logic [DW-1:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_imem_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_IF_WAIT(MAXW),
    .BOOT_ADDR  (BOOT)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .flush_i    (flush_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .ls_req_i   (ls_req_i),
    .ls_addr_i  (ls_addr_i),
    .ls_gnt_o   (ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o (ls_rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // SPROM: data for the address presented at a clock edge appears after that edge.
  always @(posedge clk_i) mem_rdata_i <= mem_f(mem_addr_o);

  // Reference model state: which read is in flight, its address, last issued address.
  bit          pend_if = 1'b0, pend_ls = 1'b0;
  logic [31:0] pend_addr = '0, last_addr = '0;
  int          starve = 0;
  bit          e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;
  logic [31:0] e_addr;
  bit          obs_if_gnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit ir, input logic [31:0] ia,
                      input bit lr, input logic [31:0] la);
    bit fair;
    @(posedge clk_i);
    #1;
    rstn_i    = !rst;
    flush_i   = fl;
    if_req_i  = ir;
    if_addr_i = ia;
    ls_req_i  = lr;
    ls_addr_i = la;
`ifdef IMEM_ARB_FAIR_EN
    fair = ir && (starve == MAXW);
`else
    fair = 1'b0;
`endif
    e_ls_gnt = !rst && lr && !fair;
    e_if_gnt = !rst && ir && !e_ls_gnt;
    e_addr   = rst ? BOOT : e_ls_gnt ? la : e_if_gnt ? ia : last_addr;
    e_if_rv  = !rst && pend_if && !fl;
    e_ls_rv  = !rst && pend_ls;
    #1;
    check_val("if_gnt",    32'(if_gnt_o),    32'(e_if_gnt));
    check_val("ls_gnt",    32'(ls_gnt_o),    32'(e_ls_gnt));
    check_val("mem_addr",  mem_addr_o,       e_addr);
    check_val("if_rvalid", 32'(if_rvalid_o), 32'(e_if_rv));
    check_val("ls_rvalid", 32'(ls_rvalid_o), 32'(e_ls_rv));
    check_val("if_rdata",  if_rdata_o,       e_if_rv ? mem_f(pend_addr) : 32'h0);
    check_val("ls_rdata",  ls_rdata_o,       e_ls_rv ? mem_f(pend_addr) : 32'h0);
    obs_if_gnt = if_gnt_o;
    if (rst) begin
      pend_if   = 1'b0;
      pend_ls   = 1'b0;
      last_addr = BOOT;
      starve    = 0;
    end else begin
      pend_if   = e_if_gnt && !fl;
      pend_ls   = e_ls_gnt;
      pend_addr = e_addr;
      last_addr = e_addr;
      starve    = (ir && !e_if_gnt) ? starve + 1 : 0;
    end
  endtask

  bit          ir, lr, rs, fl, prev_rs;
  logic [31:0] ia, la;
  logic [4:0]  gnt_mask, exp_mask;

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_addr_i = '0;

    step(1, 0, 1, 32'h44, 1, 32'h48);
    step(1, 0, 0, 0, 0, 0);

    // IF-only stream, then idle
    step(0, 0, 1, 32'h0, 0, 0);
    step(0, 0, 1, 32'h4, 0, 0);
    step(0, 0, 1, 32'h8, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // collision, LS wins, IF retries when LS drops
    step(0, 0, 1, 32'h20, 1, 32'h40);
    step(0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // flush on the grant cycle, then flush on the response cycle
    step(0, 1, 1, 32'hC, 0, 0);
    step(0, 0, 1, 32'h10, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // idle hold after reading 0x10
    step(0, 0, 1, 32'h10, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_val("idle_hold_addr", mem_addr_o, 32'h10);

    // both requesters held: IF gets the 5th cycle only with fairness enabled
    gnt_mask = '0;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 32'h80, 1, 32'h84);
      gnt_mask[k] = obs_if_gnt;
    end
`ifdef IMEM_ARB_FAIR_EN
    exp_mask = 5'b10000;
`else
    exp_mask = 5'b00000;
`endif
    check_val("fair_if_gnt_pattern", 32'(gnt_mask), 32'(exp_mask));
    step(0, 0, 0, 0, 0, 0);

    // reset right after an LS grant drops the response
    step(0, 0, 0, 0, 1, 32'h60);
    step(1, 0, 1, 32'h64, 1, 32'h68);
    step(0, 0, 0, 0, 0, 0);

    // randomized traffic; an ungranted request is held with the same address
    ir = 1'b0; lr = 1'b0; ia = '0; la = '0; prev_rs = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 4) == 0);
      if (!ir || e_if_gnt || prev_rs) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!lr || e_ls_gnt || prev_rs) begin
        lr = ($urandom_range(0, 2) == 0);
        la = 32'($urandom_range(0, 255)) << 2;
      end
      step(rs, fl, ir, ia, lr, la);
      prev_rs = rs;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
